// File: rtl/led_scan_pkg.sv
// ----------------------------------------------------------------------------
// led_scan_pkg
// Shared sizing and field-layout helpers for the bi-colour seven-segment LED
// scan driver.
//
// Frame layout (first bit shifted = MSB):
//   { digit[NUM_DIGITS-1], ..., digit[0], bright[BRIGHT_W-1:0] }
// Each digit record (LSB first):
//   anode[LEDS-1:0] | grn[SEGS-1:0] | red[SEGS-1:0]
// ----------------------------------------------------------------------------
package led_scan_pkg;

  localparam int DEF_SEGS = 7;
  localparam int DEF_LEDS = 6;

  // Bit offsets inside a frame / digit record.
  localparam int BRIGHT_LSB = 0;
  localparam int ANODE_LSB  = 0;

  function automatic int dig_w(input int segs, input int leds);
    return 2 * segs + leds;
  endfunction

  function automatic int frame_w(input int num_digits, input int segs,
                                 input int leds, input int bright_w);
    return num_digits * dig_w(segs, leds) + bright_w;
  endfunction

  function automatic int grn_lsb(input int leds);
    return leds;
  endfunction

  function automatic int red_lsb(input int segs, input int leds);
    return leds + segs;
  endfunction

  // Frame bit position of the LSB of digit d's record.
  function automatic int digit_lsb(input int d, input int segs, input int leds,
                                   input int bright_w);
    return bright_w + d * dig_w(segs, leds);
  endfunction

  // Per-digit record at the default geometry.
  typedef struct packed {
    logic [DEF_SEGS-1:0] red;
    logic [DEF_SEGS-1:0] grn;
    logic [DEF_LEDS-1:0] anode;
  } digit_rec_t;

endpackage

// File: rtl/led_scan_rx.sv
// ----------------------------------------------------------------------------
// led_scan_rx
// Host-side receiver: synchronises the three-wire serial link into the clk
// domain, shifts frame bits MSB first, and on a latch edge moves a complete
// frame into the shadow buffer (or flags a framing error).
//
// Ports:
//   clk, rst_n   oscillator clock, asynchronous active-low reset
//   sclk         host serial clock (asynchronous), rising edge shifts
//   sdata        host serial data
//   latch        host frame latch (asynchronous), rising edge commits
//   pending_clr  scan side has consumed the shadow frame this cycle
//   shadow       last correctly latched frame
//   pending      shadow holds a frame not yet applied
//   frame_err    sticky: a latch arrived with bit count != FRAME_W
// ----------------------------------------------------------------------------
module led_scan_rx #(
  parameter int FRAME_W = 88
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sclk,
  input  logic               sdata,
  input  logic               latch,
  input  logic               pending_clr,
  output logic [FRAME_W-1:0] shadow,
  output logic               pending,
  output logic               frame_err
);

  localparam int CNT_W = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

  logic [1:0]         sclk_sync;
  logic [1:0]         sdata_sync;
  logic [1:0]         latch_sync;
  logic               sclk_prev;
  logic               latch_prev;
  logic               sclk_rise;
  logic               latch_rise;
  logic [FRAME_W-1:0] shift_q;
  logic [CNT_W-1:0]   bit_cnt;

  // Two-flop synchronisers plus one stage of history for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync  <= '0;
      sdata_sync <= '0;
      latch_sync <= '0;
      sclk_prev  <= 1'b0;
      latch_prev <= 1'b0;
    end else begin
      sclk_sync  <= {sclk_sync[0], sclk};
      sdata_sync <= {sdata_sync[0], sdata};
      latch_sync <= {latch_sync[0], latch};
      sclk_prev  <= sclk_sync[1];
      latch_prev <= latch_sync[1];
    end
  end

  assign sclk_rise  = sclk_sync[1] & ~sclk_prev;
  assign latch_rise = latch_sync[1] & ~latch_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the wide shift/shadow registers are reset on purpose: a reset
      // mid-transfer must leave no partial or stale frame behind.
      shift_q   <= '0;
      shadow    <= '0;
      bit_cnt   <= '0;
      pending   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (latch_rise) begin
        // A coincident sclk edge is dropped: the latch judges the count
        // as it stood before that bit.
        if (bit_cnt == CNT_FULL) begin
          shadow <= shift_q;
        end else begin
          frame_err <= 1'b1;
        end
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        shift_q <= {shift_q[FRAME_W-2:0], sdata_sync[1]};
        if (bit_cnt != CNT_SAT) begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      // A new load wins over a consume in the same cycle.
      if (latch_rise && (bit_cnt == CNT_FULL)) begin
        pending <= 1'b1;
      end else if (pending_clr) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/led_scan_driver.sv
// ----------------------------------------------------------------------------
// led_scan_driver
// Bi-colour seven-segment LED scan driver. Receives a display frame from a
// host over sclk/sdata/latch, double-buffers it, and swaps it in only at a
// scan-frame boundary so the display never tears. The scan walks every
// segment and every LED position; within each position a PWM counter gates
// the output against the global brightness.
//
// Ports:
//   clk, rst_n   oscillator clock, asynchronous active-low reset
//   sclk, sdata  host serial link (asynchronous)
//   latch        host frame commit (asynchronous, rising edge)
//   blank        synchronous force-dark
//   digit_o      per digit {red[SEGS], grn[SEGS], anode[LEDS]}, digit 0 LSBs
//   frame_err    sticky framing error
//   scan_wrap    one-cycle pulse at the end of every full scan frame
// ----------------------------------------------------------------------------
module led_scan_driver
  import led_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SEGS       = 7,
  parameter int LEDS       = 6,
  parameter int BRIGHT_W   = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   sclk,
  input  logic                                   sdata,
  input  logic                                   latch,
  input  logic                                   blank,
  output logic [NUM_DIGITS*(2*SEGS+LEDS)-1:0]    digit_o,
  output logic                                   frame_err,
  output logic                                   scan_wrap
);

  localparam int DIG_W   = dig_w(SEGS, LEDS);
  localparam int FRAME_W = frame_w(NUM_DIGITS, SEGS, LEDS, BRIGHT_W);
  localparam int GRN_LSB = grn_lsb(LEDS);
  localparam int RED_LSB = red_lsb(SEGS, LEDS);
  localparam int LED_W   = (LEDS > 1) ? $clog2(LEDS) : 1;
  localparam int SEG_W   = (SEGS > 1) ? $clog2(SEGS) : 1;

  logic [FRAME_W-1:0]          shadow;
  logic [FRAME_W-1:0]          active;
  logic                        pending;
  logic                        pending_clr;

  logic [BRIGHT_W-1:0]         pwm_cnt;
  logic [LED_W-1:0]            led_idx;
  logic [SEG_W-1:0]            seg_idx;
  logic                        pwm_wrap;
  logic                        led_last;
  logic                        seg_last;
  logic                        frame_wrap;

  logic [SEGS-1:0]             seg_hot;
  logic [LEDS-1:0]             led_hot;
  logic                        lit;
  logic [NUM_DIGITS*DIG_W-1:0] next_digits;

  led_scan_rx #(
    .FRAME_W (FRAME_W)
  ) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .sclk        (sclk),
    .sdata       (sdata),
    .latch       (latch),
    .pending_clr (pending_clr),
    .shadow      (shadow),
    .pending     (pending),
    .frame_err   (frame_err)
  );

  assign pwm_wrap    = &pwm_cnt;
  assign led_last    = (led_idx == LED_W'(LEDS - 1));
  assign seg_last    = (seg_idx == SEG_W'(SEGS - 1));
  assign frame_wrap  = pwm_wrap & led_last & seg_last;
  assign pending_clr = frame_wrap & pending;

  // Next output word from the current scan position and active frame.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    next_digits = '0;
    // NOTE: combinational blocks use blocking '=' so later statements see
    // the values just computed; only clocked state uses '<='.
    seg_hot = SEGS'(1) << seg_idx;
    led_hot = LEDS'(1) << led_idx;
    lit     = !blank && (pwm_cnt < active[BRIGHT_LSB +: BRIGHT_W]);
    if (lit) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        next_digits[d*DIG_W + RED_LSB +: SEGS] =
          active[digit_lsb(d, SEGS, LEDS, BRIGHT_W) + RED_LSB +: SEGS] & seg_hot;
        next_digits[d*DIG_W + GRN_LSB +: SEGS] =
          active[digit_lsb(d, SEGS, LEDS, BRIGHT_W) + GRN_LSB +: SEGS] & seg_hot;
        next_digits[d*DIG_W + ANODE_LSB +: LEDS] =
          active[digit_lsb(d, SEGS, LEDS, BRIGHT_W) + ANODE_LSB +: LEDS] & led_hot;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt   <= '0;
      led_idx   <= '0;
      seg_idx   <= '0;
      active    <= '0;
      scan_wrap <= 1'b0;
      digit_o   <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_wrap) begin
        led_idx <= led_last ? '0 : led_idx + 1'b1;
        if (led_last) begin
          seg_idx <= seg_last ? '0 : seg_idx + 1'b1;
        end
      end
      scan_wrap <= frame_wrap;
      // The frame swap happens only here, so a scan frame is never mixed.
      if (pending_clr) begin
        active <= shadow;
      end
      digit_o <= next_digits;
    end
  end

endmodule

// File: tb/tb_led_scan_driver.sv
// ----------------------------------------------------------------------------
// tb_led_scan_driver
// Stimulus sends frames over the serial link and pushes, per latch, the frame
// expected to become active and the expected frame_err value. A monitor walks
// time since reset, derives the scan position with plain arithmetic, pops
// frames at scan-frame boundaries and compares digit_o / scan_wrap every
// cycle (reported per 256-cycle window) and frame_err at scheduled points.
// ----------------------------------------------------------------------------
module tb_led_scan_driver;
  import led_scan_pkg::*;

  localparam int ND   = 4;
  localparam int SG   = 7;
  localparam int LD   = 6;
  localparam int BW   = 8;
  localparam int DW   = dig_w(SG, LD);
  localparam int FW   = frame_w(ND, SG, LD, BW);
  localparam int PWMN = 1 << BW;
  localparam int SCAN = SG * LD * PWMN;

  typedef struct packed {
    digit_rec_t [ND-1:0] dig;
    logic [BW-1:0]       bright;
  } frame_bits_t;

  typedef struct packed {
    frame_bits_t f;
    int          apply_n;
  } apply_t;

  typedef struct packed {
    int   k_at;
    logic val;
  } err_t;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic            sclk  = 1'b0;
  logic            sdata = 1'b0;
  logic            latch = 1'b0;
  logic            blank = 1'b0;
  logic [ND*DW-1:0] digit_o;
  logic            frame_err;
  logic            scan_wrap;

  int     total = 0;
  int     bad   = 0;
  int     k     = 0;
  logic   exp_err = 1'b0;
  apply_t apply_q[$];
  err_t   err_q[$];

  led_scan_driver #(
    .NUM_DIGITS (ND),
    .SEGS       (SG),
    .LEDS       (LD),
    .BRIGHT_W   (BW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .sdata     (sdata),
    .latch     (latch),
    .blank     (blank),
    .digit_o   (digit_o),
    .frame_err (frame_err),
    .scan_wrap (scan_wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  initial begin : monitor
    frame_bits_t      cur;
    digit_rec_t       e;
    apply_t           a;
    err_t             ev;
    logic [ND*DW-1:0] exp_dig;
    logic             exp_wrap;
    logic             blank_s;
    logic             in_reset;
    int               win_mm, win_cnt, t, n, p, pwm, led, seg;
    string            first_msg;
    cur = '0; blank_s = 1'b0; in_reset = 1'b0;
    win_mm = 0; win_cnt = 0; first_msg = "";
    forever begin
      @(posedge clk);
      if (rst_n) k++;
      @(negedge clk);
      if (!rst_n) begin
        if (win_cnt > 0)
          check($sformatf("window(partial) k=%0d %s", k, first_msg), win_mm, 0);
        win_mm = 0; win_cnt = 0; first_msg = "";
        k = 0; cur = '0;
        apply_q.delete();
        err_q.delete();
        if (!in_reset) begin
          check("reset digit_o", digit_o, 0);
          check("reset frame_err", frame_err, 0);
          check("reset scan_wrap", scan_wrap, 0);
        end
        in_reset = 1'b1;
      end else if (k > 0) begin
        in_reset = 1'b0;
        t = k - 1;
        n = t / SCAN;
        p = t % SCAN;
        if (p == 0 && n > 0) begin
          while (apply_q.size() > 0 && apply_q[0].apply_n <= n) begin
            a   = apply_q.pop_front();
            cur = a.f;
          end
        end
        pwm = p % PWMN;
        led = (p / PWMN) % LD;
        seg = p / (PWMN * LD);
        exp_dig = '0;
        if (!blank_s && pwm < int'(cur.bright)) begin
          for (int d = 0; d < ND; d++) begin
            e = '0;
            e.red[seg]   = cur.dig[d].red[seg];
            e.grn[seg]   = cur.dig[d].grn[seg];
            e.anode[led] = cur.dig[d].anode[led];
            exp_dig[d*DW +: DW] = e;
          end
        end
        exp_wrap = (k % SCAN == 0);
        if (digit_o !== exp_dig || scan_wrap !== exp_wrap) begin
          if (win_mm == 0)
            first_msg = $sformatf("first k=%0d digit_o=%h exp=%h wrap=%b exp=%b",
                                  k, digit_o, exp_dig, scan_wrap, exp_wrap);
          win_mm++;
        end
        win_cnt++;
        if (k % PWMN == 0) begin
          check($sformatf("window k=%0d %s", k, first_msg), win_mm, 0);
          win_mm = 0; win_cnt = 0; first_msg = "";
        end
        if (err_q.size() > 0 && err_q[0].k_at <= k) begin
          ev = err_q.pop_front();
          check($sformatf("frame_err k=%0d", k), frame_err, ev.val);
        end
      end
      blank_s = blank;
    end
  end

  // -------------------------------------------------------------- stimulus
  task automatic tick(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic wait_until_k(input int target);
    while (k < target) tick(1);
  endtask

  task automatic shift_bit(input logic b);
    sdata = b;
    tick(2);
    sclk = 1'b1;
    tick(4);
    sclk = 1'b0;
    tick(2);
  endtask

  task automatic do_latch(input frame_bits_t f, input logic good);
    apply_t a;
    err_t   ev;
    // Keep the commit well clear of a scan boundary so its frame is unambiguous.
    while ((k % SCAN) > SCAN - 40) tick(1);
    latch = 1'b1;
    if (good) begin
      a.f = f;
      a.apply_n = k / SCAN + 1;
      apply_q.push_back(a);
    end else begin
      exp_err = 1'b1;
    end
    ev.k_at = k + 8;
    ev.val  = exp_err;
    err_q.push_back(ev);
    tick(4);
    latch = 1'b0;
    tick(4);
  endtask

  task automatic send_frame(input frame_bits_t f, input int nbits);
    for (int i = 0; i < nbits; i++)
      shift_bit((i < FW) ? f[FW-1-i] : 1'($urandom));
    tick(4);
    do_latch(f, nbits == FW);
  endtask

  task automatic do_reset(input int cycles);
    sclk = 1'b0; sdata = 1'b0; latch = 1'b0;
    rst_n = 1'b0;
    exp_err = 1'b0;
    tick(cycles);
    rst_n = 1'b1;
  endtask

  function automatic frame_bits_t rand_frame(input logic [BW-1:0] br);
    frame_bits_t f;
    for (int d = 0; d < ND; d++) f.dig[d] = DW'($urandom);
    f.bright = br;
    return f;
  endfunction

  initial begin : stimulus
    frame_bits_t f;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle: dark display for two scan frames, wrap every SCAN cycles.
    wait_until_k(2 * SCAN + 200);

    // Full-red frame at half brightness.
    for (int d = 0; d < ND; d++) begin
      f.dig[d].red   = 7'h7F;
      f.dig[d].grn   = 7'h00;
      f.dig[d].anode = 6'h3F;
    end
    f.bright = 8'h80;
    send_frame(f, FW);
    wait_until_k(3 * SCAN + 2000);

    // Short frame flags an error and leaves the active frame alone; two good
    // frames in one scan frame: only the later one is applied.
    send_frame(rand_frame(8'h55), FW - 1);
    send_frame(rand_frame(8'h10), FW);
    send_frame(rand_frame(8'hF0), FW);
    wait_until_k(4 * SCAN + 1000);

    // Full brightness, then random blanking during its scan frame.
    f = rand_frame(8'hFF);
    f.dig[0].red   = 7'h7F;
    f.dig[0].anode = 6'h3F;
    send_frame(f, FW);
    wait_until_k(5 * SCAN + 500);
    repeat (12) begin
      blank = 1'($urandom);
      tick($urandom_range(50, 700));
    end
    blank = 1'b0;
    tick(600);

    // Reset 40 bits into a frame; the next full frame must load cleanly.
    f = rand_frame(8'hC0);
    for (int i = 0; i < 40; i++) shift_bit(f[FW-1-i]);
    do_reset(3);
    send_frame(rand_frame(8'hA0), FW);
    wait_until_k(SCAN + 1500);

    // Over-long frame (count saturates past FRAME_W) is an error too.
    send_frame(rand_frame(8'h33), FW + 2);
    wait_until_k(SCAN + 3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
